// File: rtl/pad_chain_pkg.sv
// Shared types and frame packing for the pad-frame config chain shifter.
package pad_chain_pkg;

  localparam int DEF_NUM_PADS = 32;
  localparam int DEF_CFG_W    = 6;
  localparam int WORD_W       = DEF_CFG_W + 1;
  localparam int FRAME_W      = DEF_NUM_PADS * WORD_W;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DONE
  } state_e;

  // Pad NUM_PADS-1 occupies the top word so it leaves the MSB-first shifter first.
  function automatic logic [FRAME_W-1:0] frame_pack(
    input logic [DEF_NUM_PADS-1:0]                mux,
    input logic [DEF_NUM_PADS-1:0][DEF_CFG_W-1:0] cfg
  );
    logic [FRAME_W-1:0] f;
    for (int p = 0; p < DEF_NUM_PADS; p++) begin
      f[p*WORD_W +: WORD_W] = {mux[p], cfg[p]};
    end
    return f;
  endfunction

endpackage

// File: rtl/pad_chain_tick.sv
// Serial-clock phase counter: splits each bit time into two CLK_DIV-cycle halves.
module pad_chain_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic en,
  output logic half_tick,
  output logic bit_tick,
  output logic high_half
);

  localparam int PH_W = $clog2(2*CLK_DIV);
  localparam logic [PH_W-1:0] HALF_LAST = PH_W'(CLK_DIV-1);
  localparam logic [PH_W-1:0] BIT_LAST  = PH_W'(2*CLK_DIV-1);

  logic [PH_W-1:0] phase;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      phase <= '0;
    end else if (!en || phase == BIT_LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign half_tick = en && (phase == HALF_LAST);
  assign bit_tick  = en && (phase == BIT_LAST);
  assign high_half = en && (phase > HALF_LAST);

endmodule

// File: rtl/pad_chain_shifter.sv
// Pad-frame config chain shifter: snapshots pad mux/cfg on change and shifts one latched frame.
// Optional readback compare of the chain tail is enabled with PAD_CHAIN_READBACK_EN.
module pad_chain_shifter
  import pad_chain_pkg::*;
#(
  parameter int NUM_PADS = DEF_NUM_PADS,
  parameter int CFG_W    = DEF_CFG_W,
  parameter int CLK_DIV  = 2
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [NUM_PADS-1:0][CFG_W-1:0]   pad_cfg_i,
  input  logic [NUM_PADS-1:0]              pad_mux_i,
  input  logic                             force_i,
`ifdef PAD_CHAIN_READBACK_EN
  input  logic                             chain_sdata_i,
  output logic                             err_o,
`endif
  output logic                             chain_sclk_o,
  output logic                             chain_sdata_o,
  output logic                             chain_latch_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int FW   = NUM_PADS * (CFG_W + 1);
  localparam int BC_W = $clog2(FW);

  state_e state, state_nxt;

  logic [NUM_PADS-1:0]            snap_mux, shadow_mux;
  logic [NUM_PADS-1:0][CFG_W-1:0] snap_cfg, shadow_cfg;
  logic [FW-1:0]                  shreg;
  logic [BC_W-1:0]                bitcnt;
  logic                           half_tick, bit_tick, high_half;
  logic                           tick_en, change;

  assign tick_en = (state == ST_SHIFT) || (state == ST_LATCH);
  assign change  = (pad_mux_i != shadow_mux) || (pad_cfg_i != shadow_cfg);

  pad_chain_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .en        (tick_en),
    .half_tick (half_tick),
    .bit_tick  (bit_tick),
    .high_half (high_half)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  state_nxt = ST_LOAD;
      ST_IDLE:  if (change || force_i) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_tick && bitcnt == '0) state_nxt = ST_LATCH;
      ST_LATCH: if (half_tick) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    chain_sclk_o  = 1'b0;
    chain_sdata_o = 1'b0;
    chain_latch_o = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    case (state)
      ST_IDLE:  busy_o = 1'b0;
      ST_SHIFT: begin
        chain_sclk_o  = high_half;
        chain_sdata_o = shreg[FW-1];
      end
      ST_LATCH: chain_latch_o = 1'b1;
      ST_DONE:  done_o = 1'b1;
      default:  ;
    endcase
  end

  // Snapshot is frozen from LOAD to DONE; inputs changing meanwhile wait for the IDLE compare.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      snap_mux   <= '0;
      snap_cfg   <= '0;
      shadow_mux <= '0;
      shadow_cfg <= '0;
      shreg      <= '0;
      bitcnt     <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          snap_mux <= pad_mux_i;
          snap_cfg <= pad_cfg_i;
          shreg    <= frame_pack(pad_mux_i, pad_cfg_i);
          bitcnt   <= BC_W'(FW-1);
        end
        ST_SHIFT: begin
          if (bit_tick) begin
            shreg <= {shreg[FW-2:0], 1'b0};
            if (bitcnt != '0) bitcnt <= bitcnt - 1'b1;
          end
        end
        ST_LATCH: begin
          if (half_tick) begin
            shadow_mux <= snap_mux;
            shadow_cfg <= snap_cfg;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PAD_CHAIN_READBACK_EN
  logic [FW-1:0] capture;
  logic          first_frame;
  logic          err_q;

  // The tail replays the previously applied frame, so the capture is checked against the old shadow.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      capture     <= '0;
      first_frame <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      if (state == ST_SHIFT && half_tick) begin
        capture <= {capture[FW-2:0], chain_sdata_i};
      end
      if (state == ST_LATCH && half_tick) begin
        if (!first_frame) err_q <= (capture != frame_pack(shadow_mux, shadow_cfg));
        first_frame <= 1'b0;
      end
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_pad_chain_shifter.sv
// Bench for pad_chain_shifter: serial chain model plus per-pad bit-stream reference.
module tb_pad_chain_shifter;

  localparam int NP = 32;
  localparam int CW = 6;
  localparam int CD = 2;
  localparam int WW = CW + 1;
  localparam int FW = NP * WW;
  localparam int DONE_LAT = 1 + FW*2*CD + CD;

  logic                     HCLK = 1'b0;
  logic                     HRESET = 1'b1;
  logic [NP-1:0][CW-1:0]    pad_cfg_i;
  logic [NP-1:0]            pad_mux_i;
  logic                     force_i;
  logic                     chain_sclk_o, chain_sdata_o, chain_latch_o, busy_o, done_o;

  int total = 0;
  int bad   = 0;

  logic [FW-1:0] chain_sr = '0;
  logic [FW-1:0] applied  = '0;
  bit            rx_q[$];

`ifdef PAD_CHAIN_READBACK_EN
  logic chain_sdata_i;
  logic err_o;
  bit   stuck_en = 1'b0;
  bit   tail_q[$];
  localparam int STUCK_POS = 100;
  assign chain_sdata_i = chain_sr[FW-1];
`endif

  pad_chain_shifter #(.NUM_PADS(NP), .CFG_W(CW), .CLK_DIV(CD)) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .pad_cfg_i     (pad_cfg_i),
    .pad_mux_i     (pad_mux_i),
    .force_i       (force_i),
`ifdef PAD_CHAIN_READBACK_EN
    .chain_sdata_i (chain_sdata_i),
    .err_o         (err_o),
`endif
    .chain_sclk_o  (chain_sclk_o),
    .chain_sdata_o (chain_sdata_o),
    .chain_latch_o (chain_latch_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 HCLK = ~HCLK;

  // External daisy chain: shifts on sclk rise, shadow latches copy on latch strobe.
  always @(posedge chain_sclk_o) begin
    rx_q.push_back(chain_sdata_o);
`ifdef PAD_CHAIN_READBACK_EN
    tail_q.push_back(chain_sr[FW-1]);
`endif
    chain_sr = {chain_sr[FW-2:0], chain_sdata_o};
`ifdef PAD_CHAIN_READBACK_EN
    if (stuck_en) chain_sr[STUCK_POS] = 1'b1;
`endif
  end

  always @(posedge chain_latch_o) applied = chain_sr;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // k-th bit on the wire: pads high to low, each word mux first then cfg MSB..LSB.
  function automatic bit exp_bit(input logic [NP-1:0] m, input logic [NP-1:0][CW-1:0] c, input int k);
    int pad, pos;
    pad = NP - 1 - k / WW;
    pos = CW - k % WW;
    if (pos == CW) return m[pad];
    return c[pad][pos];
  endfunction

  function automatic int stream_errs(input logic [NP-1:0] m, input logic [NP-1:0][CW-1:0] c);
    int e = 0;
    if (rx_q.size() != FW) return FW;
    for (int k = 0; k < FW; k++) if (rx_q[k] !== exp_bit(m, c, k)) e++;
    return e;
  endfunction

  function automatic int applied_errs(input logic [NP-1:0] m, input logic [NP-1:0][CW-1:0] c);
    int e = 0;
    for (int k = 0; k < FW; k++) if (applied[FW-1-k] !== exp_bit(m, c, k)) e++;
    return e;
  endfunction

  task automatic wait_frame(output int done_at, output int latch_n);
    done_at = -1;
    latch_n = 0;
    for (int c = 1; c <= 3*DONE_LAT; c++) begin
      @(negedge HCLK);
      if (chain_latch_o) latch_n++;
      if (done_o) begin
        done_at = c;
        break;
      end
    end
  endtask

  task automatic rand_inputs();
    for (int p = 0; p < NP; p++) pad_cfg_i[p] = CW'($urandom);
    pad_mux_i = NP'($urandom);
  endtask

  task automatic test_reset();
    int d, l, e;
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    total++;
    if ({chain_sclk_o, chain_sdata_o, chain_latch_o, busy_o, done_o} !== 5'b00010) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=00010",
               {chain_sclk_o, chain_sdata_o, chain_latch_o, busy_o, done_o});
    end
    HRESET = 1'b0;
    rx_q.delete();
    @(negedge HCLK);
    wait_frame(d, l);
    total++;
    if (d != DONE_LAT) begin bad++; $display("FAIL init_done_latency got=%0d exp=%0d", d, DONE_LAT); end
    total++;
    if (l != CD) begin bad++; $display("FAIL init_latch_len got=%0d exp=%0d", l, CD); end
    e = stream_errs(pad_mux_i, pad_cfg_i);
    total++;
    if (e != 0) begin bad++; $display("FAIL init_stream bits=%0d bit_errors=%0d exp=0", rx_q.size(), e); end
    @(negedge HCLK);
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL init_idle busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_single();
    int d, l, e;
    logic [6:0] last7;
    pad_cfg_i[0] = 6'h3F;
    pad_mux_i[0] = 1'b1;
    rx_q.delete();
    @(negedge HCLK);
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL single_busy_rise got=%b exp=1", busy_o); end
    wait_frame(d, l);
    total++;
    if (d != DONE_LAT) begin bad++; $display("FAIL single_done_latency got=%0d exp=%0d", d, DONE_LAT); end
    last7 = 'x;
    if (rx_q.size() == FW) for (int i = 0; i < 7; i++) last7[6-i] = rx_q[FW-7+i];
    total++;
    if (last7 !== 7'h7F) begin bad++; $display("FAIL single_last7 got=%b exp=1111111", last7); end
    e = stream_errs(pad_mux_i, pad_cfg_i);
    total++;
    if (e != 0) begin bad++; $display("FAIL single_stream bit_errors got=%0d exp=0", e); end
    e = applied_errs(pad_mux_i, pad_cfg_i);
    total++;
    if (e != 0) begin bad++; $display("FAIL single_applied bit_errors got=%0d exp=0", e); end
    @(negedge HCLK);
  endtask

  task automatic test_random();
    int d, l, e;
    for (int it = 0; it < 3; it++) begin
      rand_inputs();
      rx_q.delete();
      @(negedge HCLK);
      total++;
      if (busy_o !== 1'b1) begin bad++; $display("FAIL rand%0d_busy got=%b exp=1", it, busy_o); end
      wait_frame(d, l);
      total++;
      if (d != DONE_LAT || l != CD) begin
        bad++; $display("FAIL rand%0d_timing done=%0d latch=%0d exp=%0d/%0d", it, d, l, DONE_LAT, CD);
      end
      e = stream_errs(pad_mux_i, pad_cfg_i) + applied_errs(pad_mux_i, pad_cfg_i);
      total++;
      if (e != 0) begin bad++; $display("FAIL rand%0d_frame bit_errors got=%0d exp=0", it, e); end
      @(negedge HCLK);
      total++;
      if (busy_o !== 1'b0) begin bad++; $display("FAIL rand%0d_idle busy got=%b exp=0", it, busy_o); end
    end
  endtask

  task automatic test_mid_change();
    int d, l, e;
    logic [NP-1:0]         old_m;
    logic [NP-1:0][CW-1:0] old_c;
    logic [6:0]            first7;
    rand_inputs();
    old_m = pad_mux_i;
    old_c = pad_cfg_i;
    rx_q.delete();
    @(negedge HCLK);
    repeat (300) @(negedge HCLK);
    pad_cfg_i[31] = ~old_c[31];
    wait_frame(d, l);
    total++;
    if (d != DONE_LAT - 300) begin bad++; $display("FAIL mid_first_done got=%0d exp=%0d", d, DONE_LAT-300); end
    e = stream_errs(old_m, old_c);
    total++;
    if (e != 0) begin bad++; $display("FAIL mid_first_stream bit_errors got=%0d exp=0", e); end
    rx_q.delete();
    @(negedge HCLK);
    @(negedge HCLK);
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL mid_second_start busy got=%b exp=1", busy_o); end
    wait_frame(d, l);
    first7 = 'x;
    if (rx_q.size() == FW) for (int i = 0; i < 7; i++) first7[6-i] = rx_q[i];
    total++;
    if (first7 !== {pad_mux_i[31], pad_cfg_i[31]}) begin
      bad++; $display("FAIL mid_second_first7 got=%b exp=%b", first7, {pad_mux_i[31], pad_cfg_i[31]});
    end
    e = stream_errs(pad_mux_i, pad_cfg_i);
    total++;
    if (e != 0 || d != DONE_LAT) begin bad++; $display("FAIL mid_second_frame bit_errors=%0d done=%0d exp=0/%0d", e, d, DONE_LAT); end
    @(negedge HCLK);
  endtask

  task automatic test_force();
    int d, l, e, extra;
    force_i = 1'b1;
    rx_q.delete();
    @(negedge HCLK);
    force_i = 1'b0;
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL force_start busy got=%b exp=1", busy_o); end
    wait_frame(d, l);
    e = stream_errs(pad_mux_i, pad_cfg_i);
    total++;
    if (e != 0 || d != DONE_LAT) begin bad++; $display("FAIL force_resend bit_errors=%0d done=%0d exp=0/%0d", e, d, DONE_LAT); end
    @(negedge HCLK);
    rand_inputs();
    force_i = 1'b1;
    rx_q.delete();
    @(negedge HCLK);
    force_i = 1'b0;
    wait_frame(d, l);
    e = stream_errs(pad_mux_i, pad_cfg_i);
    total++;
    if (e != 0) begin bad++; $display("FAIL force_change_stream bit_errors got=%0d exp=0", e); end
    extra = 0;
    repeat (20) begin
      @(negedge HCLK);
      if (busy_o) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL force_change_single busy_cycles_after got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    int d, l, e;
    rand_inputs();
    rx_q.delete();
    @(negedge HCLK);
    for (int c = 0; c < 2000; c++) begin
      @(negedge HCLK);
      if (rx_q.size() >= 100) break;
    end
    total++;
    if (rx_q.size() < 100) begin bad++; $display("FAIL rstmid_reach_bit100 got=%0d exp>=100", rx_q.size()); end
    #2 HRESET = 1'b1;
    #1;
    total++;
    if ({chain_sclk_o, chain_sdata_o, chain_latch_o, busy_o, done_o} !== 5'b00010) begin
      bad++;
      $display("FAIL rstmid_outputs got=%b exp=00010",
               {chain_sclk_o, chain_sdata_o, chain_latch_o, busy_o, done_o});
    end
    @(negedge HCLK);
    HRESET = 1'b0;
    rx_q.delete();
    @(negedge HCLK);
    wait_frame(d, l);
    e = stream_errs(pad_mux_i, pad_cfg_i);
    total++;
    if (e != 0 || d != DONE_LAT) begin bad++; $display("FAIL rstmid_resend bit_errors=%0d done=%0d exp=0/%0d", e, d, DONE_LAT); end
    e = applied_errs(pad_mux_i, pad_cfg_i);
    total++;
    if (e != 0) begin bad++; $display("FAIL rstmid_applied bit_errors got=%0d exp=0", e); end
    @(negedge HCLK);
  endtask

`ifdef PAD_CHAIN_READBACK_EN
  task automatic test_readback();
    int d, l;
    bit prev[$];
    bit exp_err;
    prev = rx_q;
    stuck_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      if (f == 2) stuck_en = 1'b0;
      if (f == 0) begin
        pad_cfg_i = '0;
        pad_mux_i = '0;
      end else begin
        force_i = 1'b1;
      end
      rx_q.delete();
      tail_q.delete();
      @(negedge HCLK);
      force_i = 1'b0;
      wait_frame(d, l);
      exp_err = (tail_q.size() != FW) || (prev.size() != FW);
      if (!exp_err) for (int k = 0; k < FW; k++) if (tail_q[k] != prev[k]) exp_err = 1'b1;
      total++;
      if (err_o !== exp_err) begin bad++; $display("FAIL readback%0d_err got=%b exp=%b", f, err_o, exp_err); end
      if (f == 1) begin
        total++;
        if (err_o !== 1'b1) begin bad++; $display("FAIL readback_stuck_detect got=%b exp=1", err_o); end
      end
      if (f == 3) begin
        total++;
        if (err_o !== 1'b0) begin bad++; $display("FAIL readback_repaired got=%b exp=0", err_o); end
      end
      prev = rx_q;
      @(negedge HCLK);
    end
  endtask
`endif

  initial begin
    pad_cfg_i = '0;
    pad_mux_i = '0;
    force_i   = 1'b0;
    test_reset();
    test_single();
    test_random();
    test_mid_change();
    test_force();
    test_reset_mid();
`ifdef PAD_CHAIN_READBACK_EN
    test_readback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
